conv_enc_stream: RTL and testbench

Streaming rate-1/2 convolutional encoder: the transmit-side counterpart of the team's Viterbi decoder, using the same code (K=3, generators 111/101, new bit inserted at the state LSB). It accepts a frame of information bits over a valid/ready handshake. It emits one 2-bit symbol per bit, and optionally K-1 zero tail symbols, in exactly the `{g0_parity, g1_parity}` layout the decoder consumes in its `syms_in` array.

---
 rtl/conv_pkg.sv | 37 +++
 rtl/conv_enc_stream_if.sv | 24 ++
 rtl/conv_enc_ctrl.sv | 147 ++++++++++++++
 rtl/conv_enc_stream.sv | 96 +++++++++
 tb/tb_conv_enc_stream.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the K=3 rate-1/2 convolutional code
// (generators 111/101, newest bit at the state LSB).
//   CONV_K, CONV_M        default constraint length and state width
//   CONV_G0, CONV_G1      default generators (symbol MSB / LSB)
//   K_MAX                 widest constraint length conv_sym supports
//   conv_state_t          encoder control FSM states
//   conv_sym(st, b)       parity pair {^(r&G0), ^(r&G1)}, r = {st, b}
package conv_pkg;

   localparam int CONV_K = 3;
   localparam int CONV_M = CONV_K - 1;
   localparam logic [CONV_K-1:0] CONV_G0 = 3'b111;
   localparam logic [CONV_K-1:0] CONV_G1 = 3'b101;

   // Operands are zero-extended to K_MAX bits. Zero-extended generators
   // mask off the extra state bits, so the parity is unchanged.
   localparam int K_MAX = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      TAIL  = 2'd2,
      FLUSH = 2'd3
   } conv_state_t;

   function automatic logic [1:0] conv_sym(
      input logic [K_MAX-2:0] st,
      input logic             b,
      input logic [K_MAX-1:0] g0 = {{(K_MAX-CONV_K){1'b0}}, CONV_G0},
      input logic [K_MAX-1:0] g1 = {{(K_MAX-CONV_K){1'b0}}, CONV_G1}
   );
      logic [K_MAX-1:0] r;
      r = {st, b};
      return {^(r & g0), ^(r & g1)};
   endfunction

endpackage

// File: rtl/conv_enc_stream_if.sv
// conv_enc_stream_if: bit-input and symbol-output handshakes of the encoder.
//   in_valid/in_bit/in_ready       information bit stream into the encoder
//   sym_valid/sym/sym_last/sym_ready  2-bit symbol stream out of the encoder
//   master: the bit source / symbol sink side
//   slave : the encoder side
interface conv_enc_stream_if;
   logic       in_valid;
   logic       in_bit;
   logic       in_ready;
   logic       sym_valid;
   logic [1:0] sym;
   logic       sym_last;
   logic       sym_ready;

   modport master (
      output in_valid, in_bit, sym_ready,
      input  in_ready, sym_valid, sym, sym_last
   );

   modport slave (
      input  in_valid, in_bit, sym_ready,
      output in_ready, sym_valid, sym, sym_last
   );
endinterface

// File: rtl/conv_enc_ctrl.sv
// conv_enc_ctrl: frame FSM and bit counter of the convolutional encoder.
// Build option: CONV_ENC_TAIL_EN adds the TAIL state (K-1 zero tail bits).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, frame_len  frame request and length (sampled when idle)
//   in_valid, in_bit  incoming information bit
//   slot_free         output register can take a symbol this cycle
//   sym_valid, sym_ready, sym_last  output register status
//   in_ready          bit accepted this cycle when in_valid
//   load, load_bit, load_last  load the output register with the symbol for
//                     load_bit, marking it last when load_last
//   clr_st            clear the shift state (frame start)
//   busy, done        frame in progress / one-cycle completion pulse
module conv_enc_ctrl
   import conv_pkg::*;
#(
   parameter int LEN_W = 8
`ifdef CONV_ENC_TAIL_EN
   , parameter int K = CONV_K
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] frame_len,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             slot_free,
   input  logic             sym_valid,
   input  logic             sym_ready,
   input  logic             sym_last,
   output logic             in_ready,
   output logic             load,
   output logic             load_bit,
   output logic             load_last,
   output logic             clr_st,
   output logic             busy,
   output logic             done
);

`ifdef CONV_ENC_TAIL_EN
   localparam logic [LEN_W-1:0] TAIL_LAST = LEN_W'(K - 2);
`endif

   conv_state_t      state_reg, state_next;
   logic [LEN_W-1:0] cnt_reg, cnt_next;
   logic [LEN_W-1:0] len_reg, len_next;
   logic             done_reg, done_next;
   logic [LEN_W-1:0] cnt_inc;

   // LEN_W-bit wrap is harmless: the compare against len_reg fires first,
   // so frame_len = 2^LEN_W-1 works.
   assign cnt_inc = cnt_reg + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         len_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         len_reg   <= len_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      len_next   = len_reg;
      done_next  = 1'b0;
      in_ready   = 1'b0;
      load       = 1'b0;
      load_bit   = 1'b0;
      load_last  = 1'b0;
      clr_st     = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               len_next = frame_len;
               cnt_next = '0;
               clr_st   = 1'b1;
               if (frame_len == '0) begin
`ifdef CONV_ENC_TAIL_EN
                  state_next = TAIL;
`else
                  state_next = FLUSH;
`endif
               end else begin
                  state_next = DATA;
               end
            end
         end

         DATA: begin
            in_ready = slot_free;
            if (in_valid && slot_free) begin
               load     = 1'b1;
               load_bit = in_bit;
               cnt_next = cnt_inc;
               if (cnt_inc == len_reg) begin
`ifdef CONV_ENC_TAIL_EN
                  cnt_next   = '0;
                  state_next = TAIL;
`else
                  load_last  = 1'b1;
                  state_next = FLUSH;
`endif
               end
            end
         end

`ifdef CONV_ENC_TAIL_EN
         // Zero bits flush the trellis back to state 0.
         TAIL: begin
            if (slot_free) begin
               load      = 1'b1;
               load_last = (cnt_reg == TAIL_LAST);
               cnt_next  = cnt_inc;
               if (cnt_reg == TAIL_LAST) begin
                  cnt_next   = '0;
                  state_next = FLUSH;
               end
            end
         end
`endif

         // In FLUSH any occupied slot holds the final symbol. An empty slot
         // only happens for an empty frame without tail bits.
         FLUSH: begin
            if (!sym_valid || (sym_ready && sym_last)) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign busy = (state_reg != IDLE);
   assign done = done_reg;

endmodule

// File: rtl/conv_enc_stream.sv
// conv_enc_stream: streaming rate-1/2 convolutional encoder. Emits one
// {g0_parity, g1_parity} symbol per information bit, in the layout the
// Viterbi decoder consumes.
// Build option: CONV_ENC_TAIL_EN appends K-1 zero tail symbols per frame.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, frame_len  begin a frame of frame_len bits (ignored while busy)
//   bus (slave)       bit input and symbol output handshakes
//   busy, done        frame in progress / pulse after last symbol consumed
module conv_enc_stream
   import conv_pkg::*;
#(
   parameter int             K     = CONV_K,
   parameter logic [K-1:0]   G0    = CONV_G0,
   parameter logic [K-1:0]   G1    = CONV_G1,
   parameter int             LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] frame_len,
   conv_enc_stream_if.slave bus,
   output logic             busy,
   output logic             done
);

   localparam int M = K - 1;
   localparam logic [K_MAX-1:0] G0_X = {{(K_MAX-K){1'b0}}, G0};
   localparam logic [K_MAX-1:0] G1_X = {{(K_MAX-K){1'b0}}, G1};

   logic [M-1:0]       st_reg;
   logic [1:0]         sym_reg;
   logic               sym_valid_reg;
   logic               sym_last_reg;
   logic               slot_free;
   logic               load, load_bit, load_last, clr_st;
   logic [K_MAX-2:0]   st_x;

   // Single-slot output register: refills in the same cycle it drains.
   assign slot_free = !sym_valid_reg || bus.sym_ready;
   assign st_x      = {{(K_MAX-1-M){1'b0}}, st_reg};

   conv_enc_ctrl #(
      .LEN_W(LEN_W)
`ifdef CONV_ENC_TAIL_EN
      , .K(K)
`endif
   ) u_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .frame_len (frame_len),
      .in_valid  (bus.in_valid),
      .in_bit    (bus.in_bit),
      .slot_free (slot_free),
      .sym_valid (sym_valid_reg),
      .sym_ready (bus.sym_ready),
      .sym_last  (sym_last_reg),
      .in_ready  (bus.in_ready),
      .load      (load),
      .load_bit  (load_bit),
      .load_last (load_last),
      .clr_st    (clr_st),
      .busy      (busy),
      .done      (done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_reg        <= '0;
         sym_reg       <= '0;
         sym_valid_reg <= 1'b0;
         sym_last_reg  <= 1'b0;
      end else begin
         if (clr_st) begin
            st_reg <= '0;
         end else if (load) begin
            st_reg <= {st_reg[M-2:0], load_bit};
         end

         if (load) begin
            sym_reg       <= conv_sym(st_x, load_bit, G0_X, G1_X);
            sym_last_reg  <= load_last;
            sym_valid_reg <= 1'b1;
         end else if (bus.sym_ready) begin
            sym_valid_reg <= 1'b0;
            sym_last_reg  <= 1'b0;
         end
      end
   end

   assign bus.sym       = sym_reg;
   assign bus.sym_valid = sym_valid_reg;
   assign bus.sym_last  = sym_last_reg;

endmodule

// File: tb/tb_conv_enc_stream.sv
// tb_conv_enc_stream: table-driven and randomized bench for conv_enc_stream,
// with a behavioural encoder model and a Viterbi decoder for loopback.
// Follows CONV_ENC_TAIL_EN the same way as the design.
module tb_conv_enc_stream;

   localparam int K     = 3;
   localparam int M     = K - 1;
   localparam int NS    = 1 << M;
   localparam int LEN_W = 8;
   localparam logic [K-1:0] G0 = 3'b111;
   localparam logic [K-1:0] G1 = 3'b101;
`ifdef CONV_ENC_TAIL_EN
   localparam int TAILN = K - 1;
`else
   localparam int TAILN = 0;
`endif

   typedef struct {
      int          len;
      logic [31:0] bits;
      bit          bp;
      logic [67:0] exp_syms;   // symbol i at [2i+1:2i], tail included
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] frame_len = '0;
   logic             busy, done;

   conv_enc_stream_if bus();

   conv_enc_stream #(.K(K), .G0(G0), .G1(G1), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .frame_len (frame_len),
      .bus       (bus),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   bit         fbits[$];
   logic [2:0] exp_q[$];
   logic [2:0] got_q[$];
   logic       prev_stall = 1'b0;
   logic [2:0] prev_out   = '0;
   int         dec_bits[300];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Symbol collector and stall-stability check, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall)
            check("stall_hold", {28'd0, bus.sym_valid, bus.sym_last, bus.sym}, {28'd0, 1'b1, prev_out});
         if (bus.sym_valid && bus.sym_ready)
            got_q.push_back({bus.sym_last, bus.sym});
         prev_stall <= bus.sym_valid && !bus.sym_ready;
         prev_out   <= {bus.sym_last, bus.sym};
      end
   end

   // Encoder rule: r = state*2 + bit, symbol = {parity(r&G0), parity(r&G1)}.
   function automatic logic [1:0] ref_sym(input int st, input int b);
      int r;
      r = (st << 1) | b;
      return {^(r & int'(G0)), ^(r & int'(G1))};
   endfunction

   function automatic void build_model();
      int st;
      int n;
      st = 0;
      n  = fbits.size();
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({(i == n - 1) && (TAILN == 0), ref_sym(st, int'(fbits[i]))});
         st = ((st << 1) | int'(fbits[i])) % NS;
      end
      for (int t = 0; t < TAILN; t++) begin
         exp_q.push_back({t == TAILN - 1, ref_sym(st, 0)});
         st = (st << 1) % NS;
      end
   endfunction

   // Hard-decision Viterbi over got_q; decoded bits land in dec_bits.
   function automatic void viterbi();
      int pm[NS];
      int npm[NS];
      int pred[300][NS];
      int n, ns, d, st, best;
      logic [1:0] e;
      n = got_q.size();
      for (int s = 0; s < NS; s++) pm[s] = (s == 0) ? 0 : 10000;
      for (int t = 0; t < n && t < 300; t++) begin
         for (int s = 0; s < NS; s++) npm[s] = 1 << 24;
         for (int s = 0; s < NS; s++) begin
            for (int b = 0; b < 2; b++) begin
               ns = ((s << 1) | b) % NS;
               e  = ref_sym(s, b);
               d  = int'(e[1] != got_q[t][1]) + int'(e[0] != got_q[t][0]);
               if (pm[s] + d < npm[ns]) begin
                  npm[ns]     = pm[s] + d;
                  pred[t][ns] = s;
               end
            end
         end
         pm = npm;
      end
      best = 0;
      if (TAILN == 0)
         for (int s = 1; s < NS; s++) if (pm[s] < pm[best]) best = s;
      st = best;
      for (int t = n - 1; t >= 0; t--) begin
         if (t < 300) begin
            dec_bits[t] = st % 2;
            st = pred[t][st];
         end
      end
   endfunction

   // Called at posedge+1; returns at posedge+1 of the done cycle.
   task automatic run_frame(input string name, input bit bp, input bit vmode, input bit poke);
      int idx, cyc, dcnt, len;
      bit fin;
      idx = 0; cyc = 0; dcnt = 0; fin = 0;
      len = fbits.size();
      got_q.delete();
      start = 1'b1;
      frame_len = LEN_W'(len);
      bus.in_valid = 1'b0;
      bus.sym_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({name, " busy"}, {31'd0, busy}, 32'd1);
      while (idx < len && cyc < 2000) begin
         bus.in_valid  = vmode ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.in_bit    = fbits[idx];
         bus.sym_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
         start         = poke && (idx == 3);
         frame_len     = poke ? LEN_W'(7) : LEN_W'(len);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) idx++;
         @(posedge clk); #1;
         cyc++;
         if (done) dcnt++;
      end
      bus.in_valid = 1'b0;
      start = 1'b0;
      while (!fin && cyc < 4000) begin
         bus.sym_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
         @(posedge clk); #1;
         cyc++;
         if (done) begin
            dcnt++;
            fin = 1;
         end
      end
      bus.sym_ready = 1'b1;
      check({name, " done"}, dcnt, 32'd1);
      check({name, " nsym"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s sym%0d", name, i), {29'd0, got_q[i]}, {29'd0, exp_q[i]});
      $display("frame %s len=%0d symbols=%0d expected=%0d cycles=%0d", name, len, got_q.size(), exp_q.size(), cyc);
   endtask

   task automatic load_vec(input vec_t v);
      fbits.delete();
      exp_q.delete();
      for (int b = 0; b < v.len; b++) fbits.push_back(v.bits[b]);
      for (int i = 0; i < v.len + TAILN; i++)
         exp_q.push_back({i == v.len + TAILN - 1, v.exp_syms[2*i +: 2]});
   endtask

   initial begin
      vec_t tbl[4];
      logic [31:0] lb;
      int rl;

      tbl[0] = '{len: 32, bits: 32'h0000_0100, bp: 1'b0, exp_syms: 68'h3B0000};
      tbl[1] = '{len: 4,  bits: 32'h0000_000F, bp: 1'b0, exp_syms: 68'hDA7};
      tbl[2] = '{len: 0,  bits: 32'h0,         bp: 1'b0, exp_syms: 68'h0};
      tbl[3] = '{len: 32, bits: 32'h0000_0100, bp: 1'b1, exp_syms: 68'h3B0000};

      bus.in_valid = 1'b0;
      bus.in_bit = 1'b0;
      bus.sym_ready = 1'b0;
      #12;
      check("reset outputs", {26'd0, bus.in_ready, bus.sym_valid, bus.sym, bus.sym_last, busy, done}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table vectors, run back to back (each start lands in the done cycle).
      for (int i = 0; i < 4; i++) begin
         load_vec(tbl[i]);
         run_frame($sformatf("tbl%0d", i), tbl[i].bp, 1'b0, 1'b0);
      end

      // Random frames with random valid gaps and backpressure.
      for (int f = 0; f < 5; f++) begin
         rl = $urandom_range(1, 40);
         fbits.delete();
         for (int b = 0; b < rl; b++) fbits.push_back(bit'($urandom_range(0, 1)));
         build_model();
         run_frame($sformatf("rand%0d", f), 1'b1, 1'b1, 1'b0);
      end

      // start pulsed mid-frame with a different frame_len: must be ignored.
      fbits.delete();
      for (int b = 0; b < 12; b++) fbits.push_back(bit'($urandom_range(0, 1)));
      build_model();
      run_frame("start_mid", 1'b0, 1'b0, 1'b1);

      // Asynchronous reset mid-frame while a symbol is stalled.
      @(posedge clk); #1;
      start = 1'b1;
      frame_len = LEN_W'(20);
      bus.in_valid = 1'b1;
      bus.in_bit = 1'b1;
      bus.sym_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("pre-reset busy/valid", {30'd0, busy, bus.sym_valid}, 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset outputs", {26'd0, bus.in_ready, bus.sym_valid, bus.sym, bus.sym_last, busy, done}, 32'd0);
      bus.in_valid = 1'b0;
      bus.sym_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      $display("reset mid-frame applied");
      load_vec(tbl[1]);
      run_frame("after_reset", 1'b0, 1'b0, 1'b0);

      // Loopback through the Viterbi decoder.
      lb = $urandom;
      fbits.delete();
      for (int b = 0; b < 32; b++) fbits.push_back(lb[b]);
      build_model();
      run_frame("loopback", 1'b1, 1'b1, 1'b0);
      viterbi();
      for (int b = 0; b < 32; b++)
         check($sformatf("loopback bit%0d", b), dec_bits[b], {31'd0, lb[b]});
      $display("loopback frame 0x%08h decoded", lb);

      // Longest legal frame.
      fbits.delete();
      for (int b = 0; b < 255; b++) fbits.push_back(bit'($urandom_range(0, 1)));
      build_model();
      run_frame("len255", 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
